imm_encoder: RTL and testbench

//  Inverse of the immediate sign-extend stage: takes a 32-bit signed immediate plus an

---
 rtl/imm_encoder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_imm_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// ============================================================================
// Module: imm_encoder
//
// Purpose
//   Inverse of the immediate sign-extend stage. Takes a 32-bit signed immediate
//   and an instruction template, then scatters the immediate into the RISC-V
//   I/S/B/J bit fields. Feeds the self-test instruction generator and the
//   instruction-memory patch loader.
//
//   Two-stage valid/ready pipeline:
//     S1 - registers the request together with its range/alignment verdict
//     S2 - merges the immediate fields into the template and holds the result
//   Requests that fail the check come out with Err_o=1. Each errored result
//   that transfers bumps a saturating counter.
//
// Configuration
//   IMM_ENCODER_UTYPE_EN - when defined, ImmSrc_i=011 encodes a U-type
//                          immediate ([31:12]=imm[31:12], imm[11:0] must be 0).
//                          When undefined, 011 is treated as unsupported.
//
// Parameters
//   DATA_WIDTH  instruction/immediate width, only 32 is supported
//   CNT_WIDTH   width of the saturating error counter
//
// Ports
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           asynchronous active-high reset
//   Valid_i   in   1           request valid
//   Ready_o   out  1           encoder can accept a request this cycle
//   ImmSrc_i  in   3           000=I 001=B 010=S 100=J 011=U (macro only)
//   Imm_i     in   DATA_WIDTH  signed immediate (byte offset for B/J)
//   Base_i    in   DATA_WIDTH  template; immediate field bits are ignored
//   Valid_o   out  1           result valid
//   Ready_i   in   1           downstream accepts the result
//   Instr_o   out  DATA_WIDTH  encoded instruction
//   Err_o     out  1           result is an error (qualified by Valid_o)
//   ErrCnt_o  out  CNT_WIDTH   saturating count of errored results
// ============================================================================
module imm_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic [2:0]            ImmSrc_i,
    input  logic [DATA_WIDTH-1:0] Imm_i,
    input  logic [DATA_WIDTH-1:0] Base_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic                  Err_o,
    output logic [CNT_WIDTH-1:0]  ErrCnt_o
);

    // Immediate source encodings
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_B = 3'b001;
    localparam logic [2:0] SRC_S = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    // S1 only needs the immediate bits some supported format can place.
    // Without U-type the widest field is J (imm[20:0]).
`ifdef IMM_ENCODER_UTYPE_EN
    localparam int IMM_KEEP = 32;
`else
    localparam int IMM_KEEP = 21;
`endif

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_e;

    stage_e                  s1State_q, s1State_d;
    stage_e                  s2State_q, s2State_d;

    logic [IMM_KEEP-1:0]     s1Imm_q,   s1Imm_d;
    logic [DATA_WIDTH-1:0]   s1Base_q,  s1Base_d;
    logic [2:0]              s1Src_q,   s1Src_d;
    logic                    s1Err_q,   s1Err_d;

    logic [DATA_WIDTH-1:0]   instr_q,   instr_d;
    logic                    err_q,     err_d;
    logic [CNT_WIDTH-1:0]    errCnt_q,  errCnt_d;

    logic                    s1Load;
    logic                    s1Advance;
    logic                    s2Free;
    logic                    outXfer;
    logic                    rangeOk;
    logic                    fits12;
    logic                    fits13;
    logic                    fits21;
    logic [DATA_WIDTH-1:0]   fieldMask;
    logic [DATA_WIDTH-1:0]   fieldBits;
    logic [DATA_WIDTH-1:0]   mergedInstr;

    // ------------------------------------------------------------------------
    // Handshake glue. S2 can take a new result when it is empty or its current
    // result leaves this cycle. Ready_o only looks at stage occupancy and
    // Ready_i, never at Valid_i.
    // ------------------------------------------------------------------------
    always_comb begin
        s2Free    = (s2State_q == STAGE_EMPTY) || Ready_i;
        s1Advance = (s1State_q == STAGE_FULL) && s2Free;
        s1Load    = Valid_i && Ready_o;
        outXfer   = (s2State_q == STAGE_FULL) && Ready_i;
    end

    // ------------------------------------------------------------------------
    // Stage occupancy: state registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1State_q <= STAGE_EMPTY;
            s2State_q <= STAGE_EMPTY;
        end else begin
            s1State_q <= s1State_d;
            s2State_q <= s2State_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage occupancy: next state. A stage goes EMPTY only when it advances
    // without being refilled in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        s1State_d = s1State_q;
        s2State_d = s2State_q;

        case (s1State_q)
            STAGE_EMPTY: if (s1Load) s1State_d = STAGE_FULL;
            STAGE_FULL:  if (s1Advance && !s1Load) s1State_d = STAGE_EMPTY;
            default:     s1State_d = STAGE_EMPTY;
        endcase

        case (s2State_q)
            STAGE_EMPTY: if (s1Advance) s2State_d = STAGE_FULL;
            STAGE_FULL:  if (Ready_i && !s1Advance) s2State_d = STAGE_EMPTY;
            default:     s2State_d = STAGE_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage occupancy: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        Ready_o = (s1State_q == STAGE_EMPTY) || s2Free;
        Valid_o = (s2State_q == STAGE_FULL);
    end

    // ------------------------------------------------------------------------
    // Range/alignment check on the incoming request. A value fits an N-bit
    // signed field when every bit from N-1 upward equals the sign bit.
    // ------------------------------------------------------------------------
    always_comb begin
        fits12  = (Imm_i[31:11] == 21'h0) || (Imm_i[31:11] == {21{1'b1}});
        fits13  = (Imm_i[31:12] == 20'h0) || (Imm_i[31:12] == {20{1'b1}});
        fits21  = (Imm_i[31:20] == 12'h0) || (Imm_i[31:20] == {12{1'b1}});
        rangeOk = 1'b0;
        case (ImmSrc_i)
            SRC_I,
            SRC_S:   rangeOk = fits12;
            SRC_B:   rangeOk = fits13 && !Imm_i[0];
            SRC_J:   rangeOk = fits21 && !Imm_i[0];
`ifdef IMM_ENCODER_UTYPE_EN
            SRC_U:   rangeOk = (Imm_i[11:0] == 12'h0);
`endif
            default: rangeOk = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // S1 capture
    // ------------------------------------------------------------------------
    always_comb begin
        s1Imm_d  = s1Imm_q;
        s1Base_d = s1Base_q;
        s1Src_d  = s1Src_q;
        s1Err_d  = s1Err_q;
        if (s1Load) begin
            s1Imm_d  = Imm_i[IMM_KEEP-1:0];
            s1Base_d = Base_i;
            s1Src_d  = ImmSrc_i;
            s1Err_d  = !rangeOk;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1Imm_q  <= '0;
            s1Base_q <= '0;
            s1Src_q  <= '0;
            s1Err_q  <= 1'b0;
        end else begin
            s1Imm_q  <= s1Imm_d;
            s1Base_q <= s1Base_d;
            s1Src_q  <= s1Src_d;
            s1Err_q  <= s1Err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Field merge. fieldMask marks the template bits owned by the immediate
    // for this format; fieldBits holds the scattered immediate. Errored
    // results keep the mask (fields forced to 0) but drop the bits. An
    // unsupported format owns no bits, so its template passes through whole.
    // ------------------------------------------------------------------------
    always_comb begin
        fieldMask = '0;
        fieldBits = '0;
        case (s1Src_q)
            SRC_I: begin
                fieldMask[31:20] = '1;
                fieldBits[31:20] = s1Imm_q[11:0];
            end
            SRC_S: begin
                fieldMask[31:25] = '1;
                fieldMask[11:7]  = '1;
                fieldBits[31:25] = s1Imm_q[11:5];
                fieldBits[11:7]  = s1Imm_q[4:0];
            end
            SRC_B: begin
                fieldMask[31:25] = '1;
                fieldMask[11:7]  = '1;
                fieldBits[31]    = s1Imm_q[12];
                fieldBits[30:25] = s1Imm_q[10:5];
                fieldBits[11:8]  = s1Imm_q[4:1];
                fieldBits[7]     = s1Imm_q[11];
            end
            SRC_J: begin
                fieldMask[31:12] = '1;
                fieldBits[31]    = s1Imm_q[20];
                fieldBits[30:21] = s1Imm_q[10:1];
                fieldBits[20]    = s1Imm_q[11];
                fieldBits[19:12] = s1Imm_q[19:12];
            end
`ifdef IMM_ENCODER_UTYPE_EN
            SRC_U: begin
                fieldMask[31:12] = '1;
                fieldBits[31:12] = s1Imm_q[31:12];
            end
`endif
            default: begin
                fieldMask = '0;
                fieldBits = '0;
            end
        endcase
        mergedInstr = (s1Base_q & ~fieldMask) | (s1Err_q ? '0 : fieldBits);
    end

    // ------------------------------------------------------------------------
    // S2 result and error counter. The result only changes when S1 advances,
    // which keeps it stable while downstream applies backpressure. The counter
    // counts errored results as they leave and sticks at all-ones.
    // ------------------------------------------------------------------------
    always_comb begin
        instr_d  = instr_q;
        err_d    = err_q;
        errCnt_d = errCnt_q;
        if (s1Advance) begin
            instr_d = mergedInstr;
            err_d   = s1Err_q;
        end
        if (outXfer && err_q && !(&errCnt_q)) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q  <= '0;
            err_q    <= 1'b0;
            errCnt_q <= '0;
        end else begin
            instr_q  <= instr_d;
            err_q    <= err_d;
            errCnt_q <= errCnt_d;
        end
    end

    assign Instr_o  = instr_q;
    assign Err_o    = err_q;
    assign ErrCnt_o = errCnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Testbench: tb_imm_encoder
//
// Purpose
//   Drives directed requests into imm_encoder and checks every valid result
//   against a format-level reference model held in an expectation queue.
//   Literal expectations for the worked examples pin the model. Honours
//   IMM_ENCODER_UTYPE_EN the same way the design does.
// ============================================================================
module tb_imm_encoder;

    logic        clk_i;
    logic        rst_i;
    logic        Valid_i;
    logic        Ready_o;
    logic [2:0]  ImmSrc_i;
    logic [31:0] Imm_i;
    logic [31:0] Base_i;
    logic        Valid_o;
    logic        Ready_i;
    logic [31:0] Instr_o;
    logic        Err_o;
    logic [7:0]  ErrCnt_o;

    imm_encoder #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .Valid_i (Valid_i),
        .Ready_o (Ready_o),
        .ImmSrc_i(ImmSrc_i),
        .Imm_i   (Imm_i),
        .Base_i  (Base_i),
        .Valid_o (Valid_o),
        .Ready_i (Ready_i),
        .Instr_o (Instr_o),
        .Err_o   (Err_o),
        .ErrCnt_o(ErrCnt_o)
    );

    // 10 time-unit clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   modelCnt = 0;
    int   outCount = 0;
    bit   randReady = 0;
    exp_t expQ[$];

    // Boundary vectors just inside and just outside each legal range
    logic [2:0] bSrc [17] = '{3'b000, 3'b000, 3'b000, 3'b000,
                              3'b010, 3'b010,
                              3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                              3'b100, 3'b100, 3'b100, 3'b100,
                              3'b101, 3'b110};
    int         bImm [17] = '{2047, -2048, 2048, -2049,
                              2047, -2049,
                              4094, -4096, 4096, 4095, -4098,
                              1048574, -1048576, 1048576, 1048575,
                              12, -12};

    // Reference model: range test on the signed value, then build the word
    // as template-with-field-cleared plus shifted immediate slices.
    function automatic exp_t modelEncode(input logic [2:0]  src,
                                         input logic [31:0] imm,
                                         input logic [31:0] base);
        exp_t        r;
        longint      v;
        bit          ok;
        logic [31:0] keep;
        logic [31:0] field;
        v = longint'($signed(imm));
        case (src)
            3'b000: begin
                ok    = (v >= -2048) && (v <= 2047);
                keep  = 32'h000F_FFFF;
                field = imm << 20;
            end
            3'b010: begin
                ok    = (v >= -2048) && (v <= 2047);
                keep  = 32'h01FF_F07F;
                field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'b001: begin
                ok    = (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
                keep  = 32'h01FF_F07F;
                field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                        (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            3'b100: begin
                ok    = (v >= -(64'sd1 << 20)) && (v <= (64'sd1 << 20) - 2) && (imm[0] == 1'b0);
                keep  = 32'h0000_0FFF;
                field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                        (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000);
            end
`ifdef IMM_ENCODER_UTYPE_EN
            3'b011: begin
                ok    = ((imm & 32'hFFF) == 0);
                keep  = 32'h0000_0FFF;
                field = imm & 32'hFFFF_F000;
            end
`endif
            default: begin
                ok    = 1'b0;
                keep  = 32'hFFFF_FFFF;
                field = 32'h0;
            end
        endcase
        r.err   = !ok;
        r.instr = ok ? ((base & keep) | field) : (base & keep);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic applyStimulus(input logic [2:0] src, input logic [31:0] imm,
                                 input logic [31:0] base);
        bit accepted;
        accepted = 0;
        ImmSrc_i = src;
        Imm_i    = imm;
        Base_i   = base;
        Valid_i  = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk_i);
            accepted = Ready_o;
            @(posedge clk_i);
            #1;
            if (randReady) Ready_i = 1'($urandom_range(0, 1));
            if (accepted) break;
        end
        Valid_i = 1'b0;
        checkOutput("accept_timeout", {31'h0, accepted}, 32'h1);
    endtask

    // Send one request and compare its result against literal values
    task automatic runOne(input string name, input logic [2:0] src,
                          input logic [31:0] imm, input logic [31:0] base,
                          input logic [31:0] expInstr, input logic expErr);
        bit seen;
        seen = 0;
        applyStimulus(src, imm, base);
        for (int w = 0; w < 20; w++) begin
            @(negedge clk_i);
            if (Valid_o) begin
                seen = 1;
                break;
            end
        end
        checkOutput({name, "_valid"}, {31'h0, seen}, 32'h1);
        checkOutput({name, "_instr"}, Instr_o, expInstr);
        checkOutput({name, "_err"}, {31'h0, Err_o}, {31'h0, expErr});
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitDrain(input string name);
        Ready_i   = 1'b1;
        randReady = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk_i);
            if (expQ.size() == 0 && !Valid_o) break;
        end
        checkOutput({name, "_drain"}, expQ.size(), 32'h0);
        @(posedge clk_i);
        #1;
    endtask

    // Compare process: checks the counter every cycle, every valid result
    // against the head of the expectation queue, result stability under
    // backpressure, and records each accepted request.
    logic        holdPrev = 0;
    logic [31:0] prevInstr;
    logic        prevErr;
    always @(negedge clk_i) begin
        if (rst_i) begin
            expQ.delete();
            modelCnt = 0;
            holdPrev = 0;
        end else begin
            checkOutput("errcnt", {24'h0, ErrCnt_o}, modelCnt);
            if (holdPrev) begin
                checkOutput("hold_valid", {31'h0, Valid_o}, 32'h1);
                checkOutput("hold_instr", Instr_o, prevInstr);
                checkOutput("hold_err", {31'h0, Err_o}, {31'h0, prevErr});
            end
            if (Valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", {31'h0, Valid_o}, 32'h0);
                end else begin
                    checkOutput("model_instr", Instr_o, expQ[0].instr);
                    checkOutput("model_err", {31'h0, Err_o}, {31'h0, expQ[0].err});
                    if (Ready_i) begin
                        if (expQ[0].err && modelCnt < 255) modelCnt++;
                        void'(expQ.pop_front());
                        outCount++;
                    end
                end
            end
            holdPrev  = Valid_o && !Ready_i;
            prevInstr = Instr_o;
            prevErr   = Err_o;
            if (Valid_i && Ready_o) expQ.push_back(modelEncode(ImmSrc_i, Imm_i, Base_i));
        end
    end

    initial begin
        int  idx;
        int  acceptedBeforeDrop;
        int  outStart;
        bit  dropped;
        bit  acc;
        logic [2:0]  s5Src  [4] = '{3'b000, 3'b010, 3'b001, 3'b100};
        logic [31:0] s5Imm  [4] = '{32'd5, 32'd100, 32'hFFFF_FFF0, 32'd4096};
        logic [31:0] s5Base [4] = '{32'h0000_0093, 32'h0000_2023, 32'h0000_1063, 32'h0000_00EF};

        rst_i    = 1'b1;
        Valid_i  = 1'b0;
        Ready_i  = 1'b0;
        ImmSrc_i = 3'b000;
        Imm_i    = 32'h0;
        Base_i   = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_valid", {31'h0, Valid_o}, 32'h0);
        checkOutput("rst_instr", Instr_o, 32'h0);
        checkOutput("rst_err", {31'h0, Err_o}, 32'h0);
        checkOutput("rst_errcnt", {24'h0, ErrCnt_o}, 32'h0);
        rst_i   = 1'b0;
        Ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("idle_ready", {31'h0, Ready_o}, 32'h1);

        // Example 1 with explicit two-cycle latency
        $display("[TB] I-type latency");
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0013);
        checkOutput("lat_not_yet", {31'h0, Valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        checkOutput("lat_valid", {31'h0, Valid_o}, 32'h1);
        checkOutput("ex1_instr", Instr_o, 32'hFFF0_0013);
        checkOutput("ex1_err", {31'h0, Err_o}, 32'h0);
        @(posedge clk_i);
        #1;

        $display("[TB] literal examples");
        runOne("ex2_s", 3'b010, 32'd8, 32'h0000_2023, 32'h0000_2423, 1'b0);
        runOne("ex2_b", 3'b001, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        runOne("ex3_j", 3'b100, 32'd2048, 32'h0000_006F, 32'h0010_006F, 1'b0);
        runOne("ex3_jerr", 3'b100, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1);
        checkOutput("ex3_errcnt", {24'h0, ErrCnt_o}, 32'd1);
        runOne("ex4_bodd", 3'b001, 32'd3, 32'h0000_0063, 32'h0000_0063, 1'b1);
        checkOutput("ex4_errcnt1", {24'h0, ErrCnt_o}, 32'd2);
        runOne("ex4_bad", 3'b111, 32'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        checkOutput("ex4_errcnt2", {24'h0, ErrCnt_o}, 32'd3);

        $display("[TB] boundary vectors with random backpressure");
        randReady = 1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(bSrc[i], 32'(bImm[i]), $urandom);
        end
        waitDrain("boundary");

        $display("[TB] streaming under backpressure");
        Ready_i            = 1'b0;
        idx                = 0;
        acceptedBeforeDrop = 0;
        dropped            = 0;
        outStart           = outCount;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            ImmSrc_i = s5Src[idx];
            Imm_i    = s5Imm[idx];
            Base_i   = s5Base[idx];
            Valid_i  = 1'b1;
            @(negedge clk_i);
            acc = Ready_o;
            if (!Ready_o) dropped = 1;
            if (acc && !dropped) acceptedBeforeDrop++;
            @(posedge clk_i);
            #1;
            if (acc) idx++;
            if (c == 2) Ready_i = 1'b1;
        end
        Valid_i = 1'b0;
        checkOutput("bp_accepted_before_drop", acceptedBeforeDrop, 32'd2);
        checkOutput("bp_all_sent", idx, 32'd4);
        waitDrain("bp");
        checkOutput("bp_results_out", outCount - outStart, 32'd4);

        $display("[TB] counter saturation");
        ImmSrc_i = 3'b111;
        Imm_i    = 32'h0;
        Base_i   = 32'h1234_5678;
        Valid_i  = 1'b1;
        repeat (300) @(posedge clk_i);
        #1;
        Valid_i = 1'b0;
        waitDrain("sat");
        checkOutput("sat_errcnt", {24'h0, ErrCnt_o}, 32'hFF);

        $display("[TB] reset with requests in flight");
        applyStimulus(3'b000, 32'd1, 32'h0000_0013);
        applyStimulus(3'b100, 32'd3, 32'h0000_006F);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'h0, Valid_o}, 32'h0);
        checkOutput("midrst_errcnt", {24'h0, ErrCnt_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("no_replay", {31'h0, Valid_o}, 32'h0);

        $display("[TB] U-type encoding");
`ifdef IMM_ENCODER_UTYPE_EN
        runOne("utype", 3'b011, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0);
        runOne("utype_err", 3'b011, 32'h1234_5001, 32'hFFFF_F537, 32'h0000_0537, 1'b1);
`else
        runOne("utype_off", 3'b011, 32'h1234_5000, 32'h0000_0537, 32'h0000_0537, 1'b1);
`endif
        waitDrain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] global timeout");
    end

endmodule
